// File: rtl/pipe_spawn_sched.sv
// Pipe slot scheduler: hands out a fixed pool of pipe slots at a fixed spawn interval,
// gives each new pipe a pseudo-random gap height, and freezes with the game state.
module pipe_spawn_sched #(
  parameter int          N_PIPES        = 3,
  parameter int          SPAWN_INTERVAL = 148500000,
  parameter int          CNT_W          = 32,
  parameter int          GAP_W          = 10,
  parameter int          GAP_MIN        = 120,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     game_run,
  input  logic                     game_over,
  input  logic [N_PIPES-1:0]       pipe_done,
  output logic [N_PIPES-1:0]       pipe_start,
  output logic [N_PIPES-1:0]       pipe_active,
  output logic [N_PIPES*GAP_W-1:0] gap_y,
  output logic [15:0]              pipes_spawned,
  output logic                     halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPAWN = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic [N_PIPES-1:0]         start_q, start_d;
  logic [N_PIPES-1:0]         active_q, active_d;
  logic [N_PIPES*GAP_W-1:0]   gap_q, gap_d;
  logic [15:0]                spawned_q, spawned_d;
  logic                       halted_q, halted_d;

  logic [N_PIPES-1:0]         free_slots;
  logic [N_PIPES-1:0]         slot_oh;
  logic                       slot_found;
  logic [GAP_W-1:0]           new_gap;
  logic [15:0]                lfsr_step;

  // A slot whose pipe leaves this very cycle is already reusable.
  assign free_slots = ~active_q | pipe_done;
  assign new_gap    = GAP_W'(GAP_MIN) + GAP_W'(lfsr_q[7:0]);
  assign lfsr_step  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    slot_oh    = '0;
    slot_found = 1'b0;
    for (int i = 0; i < N_PIPES; i++) begin
      if (free_slots[i] && !slot_found) begin
        slot_oh[i] = 1'b1;
        slot_found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    start_d   = '0;
    active_d  = active_q;
    gap_d     = gap_q;
    spawned_d = spawned_q;

    unique case (state_q)
      S_IDLE: begin
        active_d  = '0;
        spawned_d = '0;
        cnt_d     = '0;
        if (game_run) state_d = S_SPAWN;
      end

      S_SPAWN, S_WAIT: begin
        active_d = active_q & ~pipe_done;
        if (game_over) begin
          state_d = S_HALT;
        end else if (game_run) begin
          if (state_q == S_SPAWN) begin
            if (slot_found) begin
              start_d  = slot_oh;
              active_d = active_d | slot_oh;
              for (int i = 0; i < N_PIPES; i++) begin
                if (slot_oh[i]) gap_d[i*GAP_W +: GAP_W] = new_gap;
              end
              lfsr_d    = lfsr_step;
              spawned_d = (spawned_q == 16'hFFFF) ? spawned_q : spawned_q + 16'd1;
              cnt_d     = CNT_W'(1);
              state_d   = S_WAIT;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_SPAWN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_HALT: begin
        // Pipes stay drawn until the game leaves HALT; the LFSR keeps its state.
        if (!game_over && !game_run) begin
          state_d   = S_IDLE;
          active_d  = '0;
          spawned_d = '0;
          cnt_d     = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    halted_d = (state_d == S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      start_q   <= '0;
      active_q  <= '0;
      gap_q     <= '0;
      spawned_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      start_q   <= start_d;
      active_q  <= active_d;
      gap_q     <= gap_d;
      spawned_q <= spawned_d;
      halted_q  <= halted_d;
    end
  end

  assign pipe_start    = start_q;
  assign pipe_active   = active_q;
  assign gap_y         = gap_q;
  assign pipes_spawned = spawned_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_pipe_spawn_sched.sv
// Bench for pipe_spawn_sched: directed game scenarios plus random play, checked against
// a countdown-based reference model through a spawn scoreboard.
module tb_pipe_spawn_sched;

  localparam int N    = 3;
  localparam int INTV = 16;
  localparam int GW   = 10;
  localparam int GMIN = 120;
  localparam int SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst;
  logic              game_run;
  logic              game_over;
  logic [N-1:0]      pipe_done;
  logic [N-1:0]      pipe_start;
  logic [N-1:0]      pipe_active;
  logic [N*GW-1:0]   gap_y;
  logic [15:0]       pipes_spawned;
  logic              halted;

  always #5 clk = ~clk;

  pipe_spawn_sched #(
    .N_PIPES(N), .SPAWN_INTERVAL(INTV), .CNT_W(32), .GAP_W(GW),
    .GAP_MIN(GMIN), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .game_run(game_run), .game_over(game_over),
    .pipe_done(pipe_done), .pipe_start(pipe_start), .pipe_active(pipe_active),
    .gap_y(gap_y), .pipes_spawned(pipes_spawned), .halted(halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: game phase flags, a countdown to the next spawn opportunity,
  // per-slot ownership and gap heights.
  typedef struct {int slot; int gap;} spawn_t;
  spawn_t sb_q[$];

  bit m_in_game, m_halted;
  int m_wait_left, m_spawned, m_lfsr;
  bit m_active[N];
  int m_gap[N];

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 16'hFFFF;
  endfunction

  function automatic int exp_active();
    int r = 0;
    for (int i = 0; i < N; i++) if (m_active[i]) r |= (1 << i);
    return r;
  endfunction

  task automatic model_step(input bit r, input bit run, input bit over, input logic [N-1:0] done);
    int pick;
    if (r) begin
      m_in_game = 0; m_halted = 0; m_wait_left = 0; m_spawned = 0; m_lfsr = SEED;
      for (int i = 0; i < N; i++) begin m_active[i] = 0; m_gap[i] = 0; end
    end else if (!m_in_game) begin
      if (run) begin m_in_game = 1; m_wait_left = 0; end
    end else if (m_halted) begin
      if (!over && !run) begin
        m_in_game = 0; m_halted = 0; m_spawned = 0;
        for (int i = 0; i < N; i++) m_active[i] = 0;
      end
    end else if (over) begin
      m_halted = 1;
    end else begin
      pick = -1;
      if (run && m_wait_left == 0)
        for (int i = 0; i < N; i++) if ((!m_active[i] || done[i]) && pick < 0) pick = i;
      for (int i = 0; i < N; i++) if (done[i]) m_active[i] = 0;
      if (pick >= 0) begin
        m_active[pick] = 1;
        m_gap[pick]    = GMIN + (m_lfsr & 255);
        sb_q.push_back('{pick, m_gap[pick]});
        m_lfsr         = lfsr_next(m_lfsr);
        if (m_spawned < 65535) m_spawned++;
        m_wait_left    = INTV - 1;
      end else if (run && m_wait_left > 0) begin
        m_wait_left--;
      end
    end
  endtask

  // Inputs change on the falling edge; the model predicts the state after the next rise.
  task automatic step(input bit r, input bit run, input bit over, input logic [N-1:0] done);
    rst = r; game_run = run; game_over = over; pipe_done = done;
    model_step(r, run, over, done);
    @(negedge clk);
  endtask

  // Monitor: compares registered outputs just after each rising edge and pops the
  // scoreboard whenever a start pulse is expected or seen.
  always begin
    spawn_t e;
    logic [N*GW-1:0] exp_gap;
    @(posedge clk);
    #1;
    exp_gap = '0;
    for (int i = 0; i < N; i++) exp_gap[i*GW +: GW] = GW'(m_gap[i]);
    check("pipe_active", pipe_active, exp_active());
    check("pipes_spawned", pipes_spawned, m_spawned);
    check("halted", halted, m_halted);
    check("gap_y", gap_y, exp_gap);
    if (pipe_start != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_start", pipe_start, 0);
      end else begin
        e = sb_q.pop_front();
        check("pipe_start", pipe_start, 1 << e.slot);
        check("start_gap", gap_y[e.slot*GW +: GW], e.gap);
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("missing_start", 0, 1 << e.slot);
    end
  end

  task automatic run_until_spawn_ready(input string name);
    int guard = 0;
    while (m_wait_left != 0 && guard < 4 * INTV) begin
      step(0, 1, 0, '0);
      guard++;
    end
    if (m_wait_left != 0) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int cnt;
    logic [N-1:0] d;
    bit run, over, r;

    // Reset
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    check("rst_start", pipe_start, 0);
    check("rst_active", pipe_active, 0);
    check("rst_gap", gap_y, 0);
    step(0, 0, 0, '0);

    // First spawn two edges after game_run rises, gap 120 + 0xE1
    step(0, 1, 0, '0);
    check("tc1_no_early_start", pipe_start, 0);
    step(0, 1, 0, '0);
    check("tc1_start", pipe_start, 3'b001);
    check("tc1_gap", gap_y[GW-1:0], 345);
    check("tc1_active", pipe_active, 3'b001);

    // Keep running with no pipe leaving: two more spawns then a stall
    for (int i = 0; i < 100; i++) step(0, 1, 0, '0);
    check("tc2_spawned", pipes_spawned, 3);
    check("tc2_active", pipe_active, 3'b111);

    // Slot 1 leaves while stalled in SPAWN: it is reused immediately
    step(0, 1, 0, 3'b010);
    check("tc3_start", pipe_start, 3'b010);
    check("tc3_active", pipe_active, 3'b111);

    // Done on slot 0 coincident with the spawn opportunity, all slots busy
    run_until_spawn_ready("tc4");
    step(0, 1, 0, 3'b001);
    check("tc4_start", pipe_start, 3'b001);
    check("tc4_active", pipe_active, 3'b111);

    // Pause 40 cycles mid-WAIT; slot 2 leaves during the pause
    cnt = 0;
    for (int i = 0; i < 5; i++) begin step(0, 1, 0, '0); cnt++; end
    step(0, 0, 0, 3'b100); cnt++;
    for (int i = 0; i < 39; i++) begin
      step(0, 0, 0, '0); cnt++;
      if (pipe_start != '0) check("tc5_pulse_in_pause", pipe_start, 0);
    end
    while (pipe_start == '0 && cnt < 200) begin step(0, 1, 0, '0); cnt++; end
    check("tc5_spacing", cnt, INTV + 40);
    check("tc5_start", pipe_start, 3'b100);

    // game_over on the spawn cycle with slot 1 free: no pulse, frozen state
    step(0, 1, 0, 3'b010);
    run_until_spawn_ready("tc6");
    step(0, 1, 1, '0);
    check("tc6_no_start", pipe_start, 0);
    check("tc6_halted", halted, 1);
    check("tc6_active", pipe_active, 3'b101);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 3'b111);
    check("tc6_active_held", pipe_active, 3'b101);
    step(0, 0, 0, '0);
    check("tc6_idle_active", pipe_active, 0);
    check("tc6_idle_spawned", pipes_spawned, 0);
    check("tc6_idle_halted", halted, 0);

    // Reset mid-WAIT restores the LFSR seed
    for (int i = 0; i < 7; i++) step(0, 1, 0, '0);
    step(1, 1, 0, '0);
    check("tc6_rst_active", pipe_active, 0);
    check("tc6_rst_gap", gap_y, 0);
    check("tc6_rst_spawned", pipes_spawned, 0);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    check("tc6_rst_start", pipe_start, 3'b001);
    check("tc6_rst_gap0", gap_y[GW-1:0], 345);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 999) == 0);
      run  = ($urandom_range(0, 15) != 0);
      over = ($urandom_range(0, 299) == 0);
      d    = '0;
      for (int s = 0; s < N; s++) if ($urandom_range(0, 24) == 0) d[s] = 1'b1;
      if (over) d = '0;
      step(r, run, over, d);
    end

    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
